jk_bank_sequencer: RTL

Command-driven controller for a bank of WIDTH external JK flip-flops. It accepts one command at a time over a valid/ready handshake and drives per-bit J/K vectors to set, clear, toggle, load or count the bank. It reads the bank state back through q_in, so multi-step count sequences are computed from the live flop outputs. It sits between a control source (CPU or test FSM) and the JK register bank; the bank shares clk and rst with this block.

---
 rtl/jk_bank_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/jk_bank_sequencer.sv
// Command-driven set/clear/toggle/load/count controller for an external bank of JK flip-flops.
// Optional macro JK_SEQ_VERIFY_EN adds a sticky read-back check that drives err.
module jk_bank_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [2:0] OP_SET  = 3'b001;
    localparam logic [2:0] OP_CLR  = 3'b010;
    localparam logic [2:0] OP_TOG  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_UP   = 3'b101;
    localparam logic [2:0] OP_DOWN = 3'b110;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic             issue;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] tmask;
    logic [WIDTH-1:0] pat_j, pat_k;

    // Counter toggle mask: bit i flips when all lower bits are 1 (up) or 0 (down).
    function automatic logic [WIDTH-1:0] step_mask(input logic down, input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] m;
        logic             c;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = c;
            c    = c & (down ? ~q[i] : q[i]);
        end
        return m;
    endfunction

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign j_out     = j_q;
    assign k_out     = k_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Step pattern: taken from the incoming command in IDLE, from the latched one afterwards.
    always_comb begin
        sel_op   = (state_q == S_IDLE) ? cmd_op   : op_q;
        sel_data = (state_q == S_IDLE) ? cmd_data : data_q;
        tmask    = step_mask(sel_op == OP_DOWN, q_in);
        if (state_q == S_IDLE && cmd_count == '0) begin
            tmask = '0;
        end
        pat_j = '0;
        pat_k = '0;
        case (sel_op)
            OP_SET:  pat_j = sel_data;
            OP_CLR:  pat_k = sel_data;
            OP_TOG:  begin pat_j = sel_data; pat_k = sel_data; end
            OP_LOAD: begin pat_j = sel_data; pat_k = ~sel_data; end
            OP_UP,
            OP_DOWN: begin pat_j = tmask; pat_k = tmask; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    issue   = 1'b1;
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    rem_d   = ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_count != '0)
                              ? cmd_count - CNT_W'(1) : '0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: state_d = S_SETTLE;
            S_SETTLE: begin
                if (rem_q != '0) begin
                    issue   = 1'b1;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = S_APPLY;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            j_d = pat_j;
            k_d = pat_k;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= '0;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

`ifdef JK_SEQ_VERIFY_EN
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] vmask_q, vmask_d;
    logic             err_q, err_d;

    // Predict the bank value a step produces and which bits must match it in SETTLE.
    always_comb begin
        exp_d   = exp_q;
        vmask_d = vmask_q;
        err_d   = err_q;
        if (issue) begin
            exp_d = (pat_j & ~pat_k) | (~pat_j & ~pat_k & q_in) | (pat_j & pat_k & ~q_in);
            case (sel_op)
                OP_SET, OP_CLR:           vmask_d = sel_data;
                OP_LOAD, OP_UP, OP_DOWN:  vmask_d = '1;
                default:                  vmask_d = '0;
            endcase
        end
        if (state_q == S_SETTLE && ((q_in ^ exp_q) & vmask_q) != '0) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q   <= '0;
            vmask_q <= '0;
            err_q   <= 1'b0;
        end else begin
            exp_q   <= exp_d;
            vmask_q <= vmask_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
